// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - wait-state register-file memory responder for mem_rd/mem_wr strobes.
// Optional write protection of addresses below PROT_LIMIT: define MEM_WR_PROTECT_EN.
module mem_responder #(
  parameter int AWIDTH     = 5,
  parameter int DWIDTH     = 8,
  parameter int READ_LAT   = 1,
  parameter int PROT_LIMIT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] wdata,
  output logic [DWIDTH-1:0] rdata,
  output logic              rvalid,
  output logic              busy,
  output logic              wr_ack,
  output logic              proto_err,
  output logic              prot_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  localparam int         DEPTH    = 2 ** AWIDTH;
  localparam logic [3:0] CNT_INIT = (READ_LAT >= 2) ? 4'(READ_LAT - 2) : 4'd0;
  localparam logic [AWIDTH:0] PROT_LIM_W = PROT_LIMIT[AWIDTH:0];
`ifdef MEM_WR_PROTECT_EN
  localparam logic PROT_ACTIVE = 1'b1;
`else
  localparam logic PROT_ACTIVE = 1'b0;
`endif

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [AWIDTH-1:0]   addr_q, addr_d;
  logic [DWIDTH-1:0]   rdata_q, rdata_d;
  logic                wr_ack_q, wr_ack_d;
  logic                proto_err_q, proto_err_d;
  logic                prot_err_q, prot_err_d;
  logic                mem_we;
  logic                wr_blocked;
  logic [DWIDTH-1:0]   mem_q [DEPTH];

  assign wr_blocked = PROT_ACTIVE && ({1'b0, addr} < PROT_LIM_W);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    rdata_d     = rdata_q;
    wr_ack_d    = 1'b0;
    proto_err_d = proto_err_q;
    prot_err_d  = 1'b0;
    mem_we      = 1'b0;
    if (mem_rd && mem_wr) begin
      proto_err_d = 1'b1;
      state_d     = S_IDLE;
    end else if (mem_wr) begin
      if (wr_blocked) begin
        prot_err_d = 1'b1;
      end else begin
        mem_we   = 1'b1;
        wr_ack_d = 1'b1;
      end
      state_d = S_IDLE;
    end else if (mem_rd) begin
      // A new address while waiting or holding restarts the read from scratch.
      if (state_q == S_IDLE || addr != addr_q) begin
        addr_d = addr;
        if (READ_LAT == 1) begin
          rdata_d = mem_q[addr];
          state_d = S_HOLD;
        end else begin
          cnt_d   = CNT_INIT;
          state_d = S_WAIT;
        end
      end else if (state_q == S_WAIT) begin
        if (cnt_q == 4'd0) begin
          rdata_d = mem_q[addr_q];
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
    end else begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      rdata_q     <= '0;
      wr_ack_q    <= 1'b0;
      proto_err_q <= 1'b0;
      prot_err_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      rdata_q     <= rdata_d;
      wr_ack_q    <= wr_ack_d;
      proto_err_q <= proto_err_d;
      prot_err_q  <= prot_err_d;
      if (mem_we) mem_q[addr] <= wdata;
    end
  end

  assign rdata     = rdata_q;
  assign rvalid    = (state_q == S_HOLD);
  assign busy      = (state_q == S_WAIT);
  assign wr_ack    = wr_ack_q;
  assign proto_err = proto_err_q;
  assign prot_err  = prot_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed bench; instances g_dut[g] run with READ_LAT = g+1 on shared stimulus.
module tb_mem_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mem_rd = 1'b0;
  logic       mem_wr = 1'b0;
  logic [4:0] addr = '0;
  logic [7:0] wdata = '0;

  logic [7:0] rdata_o     [4];
  logic       rvalid_o    [4];
  logic       busy_o      [4];
  logic       wr_ack_o    [4];
  logic       proto_err_o [4];
  logic       prot_err_o  [4];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    mem_responder #(
      .AWIDTH(5), .DWIDTH(8), .READ_LAT(g + 1), .PROT_LIMIT(4)
    ) u_dut (
      .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .addr(addr), .wdata(wdata),
      .rdata(rdata_o[g]), .rvalid(rvalid_o[g]), .busy(busy_o[g]),
      .wr_ack(wr_ack_o[g]), .proto_err(proto_err_o[g]), .prot_err(prot_err_o[g])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #12 rst = 1'b0;
    chk8("rst_rdata", rdata_o[0], 8'h00);
    chk1("rst_rvalid", rvalid_o[0], 1'b0);
    chk1("rst_busy", busy_o[3], 1'b0);
    chk1("rst_wr_ack", wr_ack_o[0], 1'b0);
    chk1("rst_proto_err", proto_err_o[0], 1'b0);
    chk1("rst_prot_err", prot_err_o[0], 1'b0);

    // Write, start a READ_LAT=4 read, then reset while it waits with cnt=1.
    mem_wr = 1'b1; addr = 5'd3; wdata = 8'hA5;
    tick();
    chk1("wr3_ack", wr_ack_o[0], 1'b1);
    mem_wr = 1'b0; mem_rd = 1'b1;
    tick();
    chk1("lat4_busy_n", busy_o[3], 1'b1);
    chk8("lat1_pre_rst_rdata", rdata_o[0], 8'hA5);
    tick();
    chk1("lat4_busy_n1", busy_o[3], 1'b1);
    mem_rd = 1'b0;
    rst = 1'b1;
    #1;
    chk1("async_rst_busy", busy_o[3], 1'b0);
    chk1("async_rst_rvalid", rvalid_o[0], 1'b0);
    chk8("async_rst_rdata", rdata_o[0], 8'h00);
    chk1("async_rst_rvalid4", rvalid_o[3], 1'b0);
    rst = 1'b0;
    mem_rd = 1'b1; addr = 5'd3;
    tick();
    chk1("post_rst_rvalid", rvalid_o[0], 1'b1);
    chk8("post_rst_rdata", rdata_o[0], 8'h00);
    mem_rd = 1'b0;
    tick();

    // READ_LAT=1 write/read with hold.
    mem_wr = 1'b1; addr = 5'd3; wdata = 8'hA5;
    tick();
    chk1("wr3b_ack", wr_ack_o[0], 1'b1);
    mem_wr = 1'b0; mem_rd = 1'b1;
    tick();
    chk1("lat1_rvalid", rvalid_o[0], 1'b1);
    chk8("lat1_rdata", rdata_o[0], 8'hA5);
    chk1("lat1_wr_ack_clr", wr_ack_o[0], 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1("lat1_hold_rvalid", rvalid_o[0], 1'b1);
      chk8("lat1_hold_rdata", rdata_o[0], 8'hA5);
    end
    mem_rd = 1'b0;
    tick();
    chk1("lat1_drop_rvalid", rvalid_o[0], 1'b0);
    chk8("lat1_keep_rdata", rdata_o[0], 8'hA5);

    // Back-to-back writes.
    mem_wr = 1'b1; addr = 5'd7; wdata = 8'h3C;
    tick();
    chk1("wr7_ack", wr_ack_o[0], 1'b1);
    addr = 5'd8; wdata = 8'h5A;
    tick();
    chk1("wr8_ack", wr_ack_o[0], 1'b1);
    mem_wr = 1'b0;

    // READ_LAT=3 latency; READ_LAT=2 instance reaches HOLD for the address change.
    mem_rd = 1'b1; addr = 5'd7;
    tick();
    chk1("lat3_busy_n", busy_o[2], 1'b1);
    chk1("lat3_rvalid_n", rvalid_o[2], 1'b0);
    tick();
    chk1("lat3_busy_n1", busy_o[2], 1'b1);
    chk1("lat3_rvalid_n1", rvalid_o[2], 1'b0);
    tick();
    chk1("lat3_busy_n2", busy_o[2], 1'b0);
    chk1("lat3_rvalid_n2", rvalid_o[2], 1'b1);
    chk8("lat3_rdata", rdata_o[2], 8'h3C);
    chk1("lat2_hold_rvalid", rvalid_o[1], 1'b1);
    chk8("lat2_hold_rdata", rdata_o[1], 8'h3C);
    addr = 5'd8;
    tick();
    chk1("lat2_chg_rvalid_drop", rvalid_o[1], 1'b0);
    chk1("lat2_chg_busy", busy_o[1], 1'b1);
    tick();
    chk1("lat2_chg_rvalid", rvalid_o[1], 1'b1);
    chk8("lat2_chg_rdata", rdata_o[1], 8'h5A);
    mem_rd = 1'b0;
    tick();
    chk1("lat3_idle_rvalid", rvalid_o[2], 1'b0);

    // READ_LAT=3 abort: mem_rd low at edge N+1.
    mem_rd = 1'b1; addr = 5'd7;
    tick();
    mem_rd = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk1("abort_rvalid", rvalid_o[2], 1'b0);
      chk1("abort_busy", busy_o[2], 1'b0);
    end

    // Protocol error.
    mem_rd = 1'b1; mem_wr = 1'b1; addr = 5'd5; wdata = 8'hFF;
    tick();
    chk1("proto_set", proto_err_o[0], 1'b1);
    chk1("proto_no_ack", wr_ack_o[0], 1'b0);
    chk1("proto_no_rvalid", rvalid_o[0], 1'b0);
    mem_rd = 1'b0; mem_wr = 1'b0;
    tick();
    chk1("proto_sticky", proto_err_o[0], 1'b1);
    mem_rd = 1'b1;
    tick();
    chk1("proto_rd_rvalid", rvalid_o[0], 1'b1);
    chk8("proto_mem_unchanged", rdata_o[0], 8'h00);
    mem_rd = 1'b0;
    tick();

    // Write protection below PROT_LIMIT=4.
    mem_wr = 1'b1; addr = 5'd2; wdata = 8'h11;
    tick();
`ifdef MEM_WR_PROTECT_EN
    chk1("prot_blk_err", prot_err_o[0], 1'b1);
    chk1("prot_blk_ack", wr_ack_o[0], 1'b0);
`else
    chk1("prot_off_err", prot_err_o[0], 1'b0);
    chk1("prot_off_ack", wr_ack_o[0], 1'b1);
`endif
    mem_wr = 1'b0;
    tick();
    chk1("prot_pulse_end", prot_err_o[0], 1'b0);
    mem_rd = 1'b1;
    tick();
    chk1("prot_rd_rvalid", rvalid_o[0], 1'b1);
`ifdef MEM_WR_PROTECT_EN
    chk8("prot_rd_rdata", rdata_o[0], 8'h00);
`else
    chk8("prot_rd_rdata", rdata_o[0], 8'h11);
`endif
    mem_rd = 1'b0; mem_wr = 1'b1; addr = 5'd4; wdata = 8'h22;
    tick();
    chk1("prot_ok_ack", wr_ack_o[0], 1'b1);
    chk1("prot_ok_err", prot_err_o[0], 1'b0);
    mem_wr = 1'b0; mem_rd = 1'b1;
    tick();
    chk8("prot_ok_rdata", rdata_o[0], 8'h22);
    mem_rd = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
